inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of prefetch buffer entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 rom_ce_i  input  1  core fetch enable.
REQ-005 rom_addr_i  input  32  core fetch address (PC), word aligned.
REQ-006 rom_data_o  output  32  instruction for rom_addr_i, valid when stallreq_o=0.
REQ-007 stallreq_o  output  1  fetch miss; the core SHALL hold the PC while high.
REQ-008 mem_req_o  output  1  registered request to instruction memory.
REQ-009 mem_addr_o  output  32  registered request address.
REQ-010 mem_ack_i  input  1  one-cycle completion strobe from memory.
REQ-011 mem_rdata_i  input  32  read data, valid with mem_ack_i.

Function
REQ-012 Buffer SHALL hold up to DEPTH {addr, data} entries in sequential address order; count range 0..DEPTH.
REQ-013 Hit: rom_ce_i=1 and buffer non-empty and head addr == rom_addr_i -> rom_data_o = head data combinationally, stallreq_o=0, head popped at the clock edge.
REQ-014 Miss: rom_ce_i=1 and no hit -> stallreq_o=1, rom_data_o=0; if rom_addr_i differs from the fetch pointer, or the buffer holds entries, the cycle is a redirect.
REQ-015 Redirect SHALL flush all entries, load fetch pointer with rom_addr_i, set pointer-valid.
REQ-016 rom_ce_i=0 -> rom_data_o=0, stallreq_o=0, no pop, no redirect; prefetch continues.
REQ-017 FSM states IDLE, REQ, DROP.
REQ-018 IDLE -> REQ when pointer-valid and count < DEPTH (after any same-cycle pop/flush); mem_req_o=1, mem_addr_o=fetch pointer from next cycle.
REQ-019 REQ: mem_req_o and mem_addr_o SHALL stay stable until mem_ack_i; exactly one request outstanding.
REQ-020 REQ with mem_ack_i and no redirect -> push {mem_addr_o, mem_rdata_i}, fetch pointer += 4 (wrapping modulo 2^32); stay REQ with next address if count after push < DEPTH, else IDLE.
REQ-021 REQ with redirect and no mem_ack_i -> DROP; memory request SHALL stay asserted at the old address.
REQ-022 REQ with redirect and mem_ack_i in the same cycle -> data discarded, no push, REQ at the new pointer next cycle.
REQ-023 DROP: on mem_ack_i, data discarded, then REQ/IDLE per REQ-018; further redirects in DROP only update the fetch pointer.
REQ-024 Push and pop in the same cycle SHALL be allowed; count unchanged.
REQ-025 Hit-to-hit throughput SHALL be one instruction per cycle with zero-wait memory; miss-to-first-hit latency SHALL be 2 cycles with zero-wait memory, plus N for N wait cycles.

Reset
REQ-026 rst=0 SHALL asynchronously clear: state IDLE, count 0, pointer-valid 0, fetch pointer 0, mem_req_o 0, mem_addr_o 0.
REQ-027 No memory request SHALL issue after reset until the first redirect.
REQ-028 Reset during REQ SHALL abandon the request; a later stray mem_ack_i in IDLE SHALL be ignored.

Structure
REQ-029 Bus widths (InstAddrBus, InstBus) and FSM state encodings SHALL live in shared defines.v.
REQ-030 Buffer storage SHALL be one sub-module, fetch_fifo (synchronous FIFO with push, pop, flush, count).

Verification
REQ-031 Reset release, rom_ce_i=1, PC=0x0, zero-wait memory -> stall cycles 0-1, hits 0x0,0x4,0x8,... back-to-back from cycle 2.
REQ-032 Memory with 3 wait cycles -> each new word hits 4 cycles after the previous one; mem_addr_o stable throughout each request.
REQ-033 rom_ce_i=0 for 10 cycles with PC held -> buffer fills to DEPTH=4, mem_req_o drops; on re-enable, 4 hits then refill.
REQ-034 Redirect to 0x100 while request for 0x10 is waiting -> DROP, 0x10 data discarded, next request addr 0x100, first hit 0x100.
REQ-035 Redirect coinciding with mem_ack_i -> no push; next cycle mem_addr_o = new PC.
REQ-036 PC=0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order; rst pulse mid-REQ -> all outputs zero asynchronously.

Source files
------------

// File: rtl/inst_prefetch_pkg.sv
// Shared widths, buffer entry layout and prefetch FSM encoding for the
// instruction prefetcher.
package inst_prefetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } pf_state_e;

    typedef struct packed {
        inst_addr_t addr;
        inst_t      data;
    } pf_entry_t;

    localparam inst_addr_t INST_STEP = 32'd4;

    // Sequential fetch address; wraps modulo 2^32 by construction.
    function automatic inst_addr_t next_pc(input inst_addr_t pc);
        return pc + INST_STEP;
    endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// Instruction-memory request/acknowledge bus. Member names are seen from the
// prefetcher side: it drives the _o members and samples the _i members.
interface inst_prefetch_if;
    import inst_prefetch_pkg::*;

    logic       mem_req_o;
    inst_addr_t mem_addr_o;
    logic       mem_ack_i;
    inst_t      mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/inst_prefetch_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {addr, data} entries with flush and
// a combinational head read so a hit is served in the fetch cycle itself.
module fetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  pf_entry_t     wdata,
    output pf_entry_t     rdata,
    output logic [CW-1:0] count
);

    pf_entry_t     store [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) store[wr_ptr_reg] <= wdata;
    end

    assign rdata = store[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: keeps up to DEPTH upcoming words ahead
// of the core PC, one memory request in flight at a time.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rom_ce_i,
    input  inst_addr_t         rom_addr_i,
    output inst_t              rom_data_o,
    output logic               stallreq_o,
    inst_prefetch_if.master    mem_bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    pf_state_e  state_reg, state_next;
    inst_addr_t ptr_reg, ptr_next;
    logic       ptr_valid_reg, ptr_valid_next;
    logic       mem_req_reg, mem_req_next;
    inst_addr_t mem_addr_reg, mem_addr_next;

    pf_entry_t     head;
    pf_entry_t     push_entry;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_after;
    logic          hit, redirect, push, can_req, busy_hold;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (hit),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count)
    );

    // A miss while the pointer is already heading to this PC with nothing
    // buffered is simply a wait; anything else restarts the stream.
    assign hit      = rom_ce_i && (fifo_count != '0) && (head.addr == rom_addr_i);
    assign redirect = rom_ce_i && !hit &&
                      (!ptr_valid_reg || (rom_addr_i != ptr_reg) || (fifo_count != '0));
    assign push     = (state_reg == ST_REQ) && mem_bus.mem_ack_i && !redirect;

    assign push_entry = '{addr: mem_addr_reg, data: mem_bus.mem_rdata_i};
    assign rom_data_o = hit ? head.data : '0;
    assign stallreq_o = rom_ce_i && !hit;

    assign mem_bus.mem_req_o  = mem_req_reg;
    assign mem_bus.mem_addr_o = mem_addr_reg;

    always_comb begin
        ptr_next       = ptr_reg;
        ptr_valid_next = ptr_valid_reg | redirect;
        if (redirect)  ptr_next = rom_addr_i;
        else if (push) ptr_next = next_pc(ptr_reg);

        count_after = redirect ? '0 : (fifo_count + CW'(push) - CW'(hit));
        can_req     = ptr_valid_next && (count_after < CW'(DEPTH));

        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (can_req) state_next = ST_REQ;
            ST_REQ: begin
                if (mem_bus.mem_ack_i) state_next = can_req ? ST_REQ : ST_IDLE;
                else if (redirect)     state_next = ST_DROP;
            end
            ST_DROP: if (mem_bus.mem_ack_i) state_next = can_req ? ST_REQ : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // The outstanding request keeps its address until memory answers,
        // even across a redirect; only a fresh request takes the pointer.
        busy_hold     = (state_reg != ST_IDLE) && !mem_bus.mem_ack_i;
        mem_req_next  = (state_next != ST_IDLE);
        mem_addr_next = mem_addr_reg;
        if (!busy_hold && (state_next == ST_REQ)) mem_addr_next = ptr_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            ptr_valid_reg <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            ptr_valid_reg <= ptr_valid_next;
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
        end
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: zero-wait and wait-state memory, buffer
// fill, redirect during a request, address wrap and asynchronous reset.
module tb_inst_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce = 1'b0;
    logic [31:0] rom_addr = '0;
    logic [31:0] rom_data;
    logic        stall;

    int          n_checks = 0;
    int          n_errors = 0;

    // Memory model: auto mode acks after mem_wait cycles; manual mode uses ack_force.
    logic        mem_auto = 1'b1;
    logic        ack_force = 1'b0;
    int          mem_wait = 0;
    int          wcnt;
    logic [31:0] pc;

    inst_prefetch_if mem_if ();

    inst_prefetch #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce),
        .rom_addr_i (rom_addr),
        .rom_data_o (rom_data),
        .stallreq_o (stall),
        .mem_bus    (mem_if.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_if.mem_ack_i   = mem_auto ? (mem_if.mem_req_o && (wcnt == mem_wait)) : ack_force;
    assign mem_if.mem_rdata_i = mem_word(mem_if.mem_addr_o);

    always @(posedge clk or negedge rst) begin
        if (!rst)                                          wcnt <= 0;
        else if (mem_if.mem_req_o && !mem_if.mem_ack_i)    wcnt <= wcnt + 1;
        else                                               wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] a);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_data"}, rom_data, mem_word(a));
        $display("txn hit pc=%h data=%h", rom_addr, rom_data);
    endtask

    // Leaves rst low at a negedge; the caller releases it and drives cycle 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; rom_ce = 1'b0; ack_force = 1'b0; mem_auto = 1'b1; mem_wait = 0;
        #1;
        chk("rst_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("rst_addr", mem_if.mem_addr_o, 32'd0);
        chk("rst_data", rom_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic start(input logic [31:0] a);
        rst = 1'b1; rom_ce = 1'b1; rom_addr = a; pc = a;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        rom_addr = pc;
        #1;
    endtask

    initial begin
        // Zero-wait memory from reset: two stall cycles, then one hit per cycle.
        do_reset();
        start(32'h0);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            if (c < 2) chk("zw_stall", 32'(stall), 32'd1);
            else begin expect_hit("zw", pc); pc += 4; end
        end

        // Three wait cycles: hits every fourth cycle, address stable per request.
        do_reset();
        mem_wait = 3;
        start(32'h40);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) step();
            if (c >= 1) begin
                chk("ws_req", 32'(mem_if.mem_req_o), 32'd1);
                chk("ws_addr", mem_if.mem_addr_o, 32'h40 + 32'(4 * ((c - 1) / 4)));
            end
            if (c == 5 || c == 9 || c == 13) begin expect_hit("ws", pc); pc += 4; end
            else chk("ws_stall", 32'(stall), 32'd1);
        end

        // Fetch disabled for 10 cycles: buffer fills and requests stop.
        do_reset();
        start(32'h200);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            if (c < 2) chk("fill_stall", 32'(stall), 32'd1);
            else begin expect_hit("fill", pc); pc += 4; end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); rom_ce = 1'b0; #1;
            if (k == 0) begin
                chk("dis_data", rom_data, 32'd0);
                chk("dis_stall", 32'(stall), 32'd0);
            end
        end
        chk("full_req", 32'(mem_if.mem_req_o), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); rom_ce = 1'b1; rom_addr = pc; #1;
            if (k == 0) chk("full_idle", 32'(mem_if.mem_req_o), 32'd0);
            if (k == 1) begin
                chk("refill_req", 32'(mem_if.mem_req_o), 32'd1);
                chk("refill_addr", mem_if.mem_addr_o, 32'h214);
            end
            expect_hit("drain", pc); pc += 4;
        end

        // Redirect while the 0x10 request waits: DROP, discard, restart at 0x100.
        do_reset();
        mem_auto = 1'b0;
        start(32'h10);
        step();
        chk("dr_req", 32'(mem_if.mem_req_o), 32'd1);
        chk("dr_addr0", mem_if.mem_addr_o, 32'h10);
        pc = 32'h100; step();
        chk("dr_stall", 32'(stall), 32'd1);
        step();
        chk("dr_hold_req", 32'(mem_if.mem_req_o), 32'd1);
        chk("dr_hold_addr", mem_if.mem_addr_o, 32'h10);
        @(negedge clk); ack_force = 1'b1; #1;
        chk("dr_ack_stall", 32'(stall), 32'd1);
        @(negedge clk); ack_force = 1'b0; #1;
        chk("dr_new_req", 32'(mem_if.mem_req_o), 32'd1);
        chk("dr_new_addr", mem_if.mem_addr_o, 32'h100);
        @(negedge clk); ack_force = 1'b1; #1;
        chk("dr_fill_stall", 32'(stall), 32'd1);
        @(negedge clk); ack_force = 1'b0; #1;
        expect_hit("dr", 32'h100);

        // Redirect in the same cycle as the ack: no push, new address next cycle.
        do_reset();
        mem_auto = 1'b0;
        start(32'h300);
        step();
        chk("ra_addr0", mem_if.mem_addr_o, 32'h300);
        @(negedge clk); rom_addr = 32'h500; pc = 32'h500; ack_force = 1'b1; #1;
        chk("ra_stall", 32'(stall), 32'd1);
        @(negedge clk); ack_force = 1'b0; #1;
        chk("ra_req", 32'(mem_if.mem_req_o), 32'd1);
        chk("ra_addr", mem_if.mem_addr_o, 32'h500);
        @(negedge clk); ack_force = 1'b1; #1;
        @(negedge clk); ack_force = 1'b0; #1;
        expect_hit("ra", 32'h500);

        // Address wrap past 0xFFFFFFFC.
        do_reset();
        start(32'hFFFF_FFF8);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) step();
            if (c >= 1 && c <= 3)
                chk("wrap_addr", mem_if.mem_addr_o, 32'hFFFF_FFF8 + 32'(4 * (c - 1)));
            if (c >= 2) begin expect_hit("wrap", pc); pc += 4; end
        end

        // Asynchronous reset mid-request, then a stray ack while idle.
        do_reset();
        mem_auto = 1'b0;
        start(32'h40);
        step();
        chk("ar_req_before", 32'(mem_if.mem_req_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("ar_addr", mem_if.mem_addr_o, 32'd0);
        chk("ar_data", rom_data, 32'd0);
        @(negedge clk); rst = 1'b1; rom_ce = 1'b0; ack_force = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); ack_force = 1'b0; #1;
            chk("ar_no_req", 32'(mem_if.mem_req_o), 32'd0);
        end
        @(negedge clk); mem_auto = 1'b1; rom_ce = 1'b1; pc = 32'h40; rom_addr = pc; #1;
        chk("ar_stall0", 32'(stall), 32'd1);
        step();
        chk("ar_stall1", 32'(stall), 32'd1);
        step();
        expect_hit("ar", 32'h40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
